// File: rtl/cla_pipelined_adder_if.sv
// Operand/result handshake bundle for cla_pipelined_adder.
// valid/ready: a beat transfers on a rising clk edge where valid & ready; the
// sender holds payload stable while valid & !ready; ready never depends on valid.
interface cla_pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             P;
   logic             G;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf, P, G
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf, P, G
   );
endinterface

// File: rtl/cla_pipelined_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor built from 4-bit CLA
// groups; stage 1 registers bit and group P/G, stage 2 resolves carries and sums.
module cla_pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int NGRP  = WIDTH / 4
) (
   input logic                  clk,
   input logic                  rst_n,
   cla_pipelined_adder_if.slave bus
);
   logic             advance1;
   logic             advance2;
   logic             v1_q, v1_d;
   logic             v2_q, v2_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic [NGRP-1:0]  gp_q, gp_d;
   logic [NGRP-1:0]  gg_q, gg_d;
   logic             c0_q, c0_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             pb_q, pb_d;
   logic             gb_q, gb_d;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] pn;
   logic [WIDTH-1:0] gn;
   logic [WIDTH-1:0] gp_ext;
   logic [WIDTH-1:0] gg_ext;
   logic [NGRP:0]    cg;
   logic [WIDTH-1:0] cb;
   logic             g_blk;

   // Carry into position k of a chain starting at lo, as one flat sum of
   // products, so neither level ripples.
   function automatic logic carry_sop(input logic [WIDTH-1:0] pv,
                                      input logic [WIDTH-1:0] gv,
                                      input logic ci, input int lo, input int k);
      logic res;
      logic term;
      term = ci;
      for (int m = lo; m < k; m++) term = term & pv[m];
      res = term;
      for (int j = lo; j < k; j++) begin
         term = gv[j];
         for (int m = j + 1; m < k; m++) term = term & pv[m];
         res = res | term;
      end
      return res;
   endfunction

   assign advance2     = ~v2_q | bus.out_ready;
   assign advance1     = ~v1_q | advance2;
   assign bus.in_ready = advance1;

   always_comb begin
      b_eff = bus.sub ? ~bus.b : bus.b;
      pn    = bus.a ^ b_eff;
      gn    = bus.a & b_eff;
      v1_d  = advance1 ? bus.in_valid : v1_q;
      p_d   = p_q;
      g_d   = g_q;
      gp_d  = gp_q;
      gg_d  = gg_q;
      c0_d  = c0_q;
      if (bus.in_valid && advance1) begin
         p_d  = pn;
         g_d  = gn;
         c0_d = bus.sub | bus.cin;
         for (int k = 0; k < NGRP; k++) begin
            gp_d[k] = &pn[4*k +: 4];
            gg_d[k] = gn[4*k+3]
                    | (pn[4*k+3] & gn[4*k+2])
                    | (pn[4*k+3] & pn[4*k+2] & gn[4*k+1])
                    | (pn[4*k+3] & pn[4*k+2] & pn[4*k+1] & gn[4*k]);
         end
      end
   end

   always_comb begin
      gp_ext = {{(WIDTH-NGRP){1'b0}}, gp_q};
      gg_ext = {{(WIDTH-NGRP){1'b0}}, gg_q};
      cg     = '0;
      cb     = '0;
      for (int k = 0; k <= NGRP; k++) cg[k] = carry_sop(gp_ext, gg_ext, c0_q, 0, k);
      for (int i = 0; i < WIDTH; i++) cb[i] = carry_sop(p_q, g_q, cg[i/4], 4*(i/4), i);
      g_blk  = carry_sop(gp_ext, gg_ext, 1'b0, 0, NGRP);
      v2_d   = advance2 ? v1_q : v2_q;
      s_d    = s_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      pb_d   = pb_q;
      gb_d   = gb_q;
      if (advance2 && v1_q) begin
         s_d    = p_q ^ cb;
         cout_d = cg[NGRP];
         ovf_d  = cb[WIDTH-1] ^ cg[NGRP];
         pb_d   = &gp_q;
         gb_d   = g_blk;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         p_q    <= '0;
         g_q    <= '0;
         gp_q   <= '0;
         gg_q   <= '0;
         c0_q   <= 1'b0;
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         pb_q   <= 1'b0;
         gb_q   <= 1'b0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         p_q    <= p_d;
         g_q    <= g_d;
         gp_q   <= gp_d;
         gg_q   <= gg_d;
         c0_q   <= c0_d;
         s_q    <= s_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         pb_q   <= pb_d;
         gb_q   <= gb_d;
      end
   end

   assign bus.out_valid = v2_q;
   assign bus.s         = s_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.P         = pb_q;
   assign bus.G         = gb_q;
endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Bench for cla_pipelined_adder: directed vectors into a scoreboard queue,
// checked by an independent output monitor; small WIDTH=4/32 side instances.
module tb_cla_pipelined_adder;
   localparam int W  = 16;
   localparam int EW = W + 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   rand_on = 0;
   logic [EW-1:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cla_pipelined_adder_if #(.WIDTH(16)) bus16 ();
   cla_pipelined_adder_if #(.WIDTH(4))  bus4 ();
   cla_pipelined_adder_if #(.WIDTH(32)) bus32 ();

   cla_pipelined_adder #(.WIDTH(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus16));
   cla_pipelined_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
   cla_pipelined_adder #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] pk(input logic [W-1:0] ts, input logic tc, input logic to,
                                        input logic tp, input logic tg);
      return {ts, tc, to, tp, tg};
   endfunction

   // Reference: plain integer arithmetic, not a lookahead structure.
   function automatic logic [EW-1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                           input logic tcin, input logic tsub);
      logic [W-1:0] be;
      logic [W:0]   sm;
      logic [W:0]   g0;
      logic         c0;
      logic         cmsb;
      be   = tsub ? ~tb_v : tb_v;
      c0   = tsub ? 1'b1 : tcin;
      sm   = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, c0};
      g0   = {1'b0, ta} + {1'b0, be};
      cmsb = ta[W-1] ^ be[W-1] ^ sm[W-1];
      return {sm[W-1:0], sm[W], cmsb ^ sm[W], &(ta ^ be), g0[W]};
   endfunction

   // Monitor: compares every presented beat with the queue head; pops on transfer.
   always @(negedge clk) begin
      if (rst_n && bus16.out_valid) begin
         if (exp_q.size() == 0) begin
            check("stray_out_valid", 64'(bus16.out_valid), 64'(0));
         end else begin
            check("result", 64'({bus16.s, bus16.cout, bus16.ovf, bus16.P, bus16.G}), 64'(exp_q[0]));
            if (bus16.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                       input logic tsub, input logic [EW-1:0] texp);
      bit done = 0;
      bus16.a = ta; bus16.b = tb_v; bus16.cin = tcin; bus16.sub = tsub;
      bus16.in_valid = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (bus16.in_ready) begin
            exp_q.push_back(texp);
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end
   endtask

   task automatic idle();
      bus16.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
      #1;
      check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      logic [W-1:0] ra, rb;
      logic rc, rs;
      bus16.in_valid = 0; bus16.out_ready = 1; bus16.a = 0; bus16.b = 0; bus16.cin = 0; bus16.sub = 0;
      bus4.in_valid = 0;  bus4.out_ready = 1;  bus4.a = 0;  bus4.b = 0;  bus4.cin = 0;  bus4.sub = 0;
      bus32.in_valid = 0; bus32.out_ready = 1; bus32.a = 0; bus32.b = 0; bus32.cin = 0; bus32.sub = 0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(bus16.out_valid), 64'(0));
      check("rst_s", 64'(bus16.s), 64'(0));
      check("rst_flags", 64'({bus16.cout, bus16.ovf, bus16.P, bus16.G}), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_rst", 64'(bus16.in_ready), 64'(1));

      // Latency: one beat, out_valid must appear exactly two edges after acceptance.
      send(16'h000A, 16'h000F, 1'b1, 1'b0, pk(16'h001A, 0, 0, 0, 0));
      idle();
      @(negedge clk) check("latency_cycle1_no_valid", 64'(bus16.out_valid), 64'(0));
      @(negedge clk) check("latency_cycle2_valid", 64'(bus16.out_valid), 64'(1));
      @(posedge clk); #1;

      // Directed vectors, back to back.
      send(16'h0005, 16'h0007, 1'b1, 1'b1, pk(16'hFFFE, 0, 0, 0, 0));
      send(16'h0007, 16'h0005, 1'b0, 1'b1, pk(16'h0002, 1, 0, 0, 1));
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0, pk(16'h0000, 1, 0, 1, 0));
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, pk(16'h8000, 0, 1, 0, 0));
      send(16'h1234, 16'h1234, 1'b0, 1'b1, pk(16'h0000, 1, 0, 1, 0));
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, pk(16'hFFFF, 1, 0, 0, 1));
      send(16'h8000, 16'h8000, 1'b0, 1'b0, pk(16'h0000, 1, 1, 0, 1));
      idle();
      drain();

      // Throughput: 8 beats with out_ready high must take 8 edges.
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 1; i <= 8; i++) begin
         logic [W-1:0] va;
         va = 16'(i * 16'h0111);
         send(va, 16'h0101, 1'b0, 1'b0, model(va, 16'h0101, 1'b0, 1'b0));
      end
      check("throughput_8_beats", 64'(cyc - t0), 64'(8));
      idle();
      drain();

      // Backpressure: two beats fill the pipe, the third must wait.
      bus16.out_ready = 1'b0;
      send(16'd1, 16'd1, 1'b0, 1'b0, pk(16'd2, 0, 0, 0, 0));
      send(16'd2, 16'd2, 1'b0, 1'b0, pk(16'd4, 0, 0, 0, 0));
      bus16.a = 16'd3; bus16.b = 16'd3; bus16.in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk) check("bp_in_ready_low", 64'(bus16.in_ready), 64'(0));
         @(posedge clk); #1;
      end
      bus16.out_ready = 1'b1;
      send(16'd3, 16'd3, 1'b0, 1'b0, pk(16'd6, 0, 0, 0, 0));
      idle();
      drain();

      // Streaming with random gaps and random consumer stalls.
      rand_on = 1;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  idle();
                  @(posedge clk); #1;
               end
               ra = 16'($urandom); rb = 16'($urandom);
               rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
               send(ra, rb, rc, rs, model(ra, rb, rc, rs));
            end
            idle();
            rand_on = 0;
         end
         begin
            while (rand_on) begin
               @(posedge clk); #1;
               bus16.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus16.out_ready = 1'b1;
      drain();

      // WIDTH=4 and WIDTH=32 instances: one beat each.
      bus4.a = 4'h7; bus4.b = 4'h1; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
      bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h0; bus32.cin = 1'b1; bus32.in_valid = 1'b1;
      @(negedge clk);
      check("w4_in_ready", 64'(bus4.in_ready), 64'(1));
      check("w32_in_ready", 64'(bus32.in_ready), 64'(1));
      @(posedge clk); #1;
      bus4.in_valid = 1'b0; bus32.in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("w4_out_valid", 64'(bus4.out_valid), 64'(1));
      check("w4_result", 64'({bus4.s, bus4.cout, bus4.ovf, bus4.P, bus4.G}), 64'({4'h8, 4'b0100}));
      check("w32_out_valid", 64'(bus32.out_valid), 64'(1));
      check("w32_result", 64'({bus32.s, bus32.cout, bus32.ovf, bus32.P, bus32.G}), 64'({32'h0, 4'b1010}));
      @(posedge clk); #1;

      // Reset with two beats in flight in every instance.
      bus16.out_ready = 1'b0; bus4.out_ready = 1'b0; bus32.out_ready = 1'b0;
      bus4.a = 4'h3; bus4.b = 4'h5; bus4.in_valid = 1'b1;
      bus32.a = 32'h1234_5678; bus32.b = 32'h1111_1111; bus32.in_valid = 1'b1;
      send(16'h0101, 16'h0202, 1'b0, 1'b0, pk(16'h0303, 0, 0, 0, 0));
      send(16'h0404, 16'h0505, 1'b0, 1'b0, pk(16'h0909, 0, 0, 0, 0));
      idle();
      bus4.in_valid = 1'b0; bus32.in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      check("midrst_w16_out_valid", 64'(bus16.out_valid), 64'(0));
      check("midrst_w16_outputs", 64'({bus16.s, bus16.cout, bus16.ovf, bus16.P, bus16.G}), 64'(0));
      check("midrst_w4_out_valid", 64'(bus4.out_valid), 64'(0));
      check("midrst_w4_outputs", 64'({bus4.s, bus4.cout, bus4.ovf, bus4.P, bus4.G}), 64'(0));
      check("midrst_w32_out_valid", 64'(bus32.out_valid), 64'(0));
      check("midrst_w32_outputs", 64'({bus32.s, bus32.cout, bus32.ovf, bus32.P, bus32.G}), 64'(0));
      exp_q.delete();
      @(negedge clk) rst_n = 1'b1;
      bus16.out_ready = 1'b1; bus4.out_ready = 1'b1; bus32.out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("post_rst_w16_no_stale", 64'(bus16.out_valid), 64'(0));
         check("post_rst_w4_no_stale", 64'(bus4.out_valid), 64'(0));
         check("post_rst_w32_no_stale", 64'(bus32.out_valid), 64'(0));
      end
      check("post_rst_in_ready", 64'(bus16.in_ready), 64'(1));
      @(posedge clk); #1;

      // Pipeline still works after the mid-operation reset.
      send(16'h00FF, 16'h0001, 1'b0, 1'b0, pk(16'h0100, 0, 0, 0, 0));
      idle();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cla_pipelined_adder.md
Name: cla_pipelined_adder

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups with augmented (group P/G) outputs.
- It extends the single combinational 4-bit CLA to WIDTH bits with a second-level lookahead unit, an add/subtract mode, overflow detection and valid/ready flow control.
- It sits between operand-producing logic and a result consumer in the ALU datapath, and exports block P/G so a higher-level lookahead unit can chain it.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4, range 4..64.
- NGRP, WIDTH/4, number of 4-bit CLA groups (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used in add mode only
- sub  input  1  1 = A - B, 0 = A + B + cin
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts the result beat
- s  output  WIDTH  sum/difference
- cout  output  1  carry out of the MSB
- ovf  output  1  signed overflow (carry into MSB XOR cout)
- P  output  1  block propagate (AND of all bit propagates of A and effective B)
- G  output  1  block generate (carry out of the MSB with carry-in forced to 0)

Behaviour:
- Reset: asynchronous on rst_n low. Both stage valid flags clear; s, cout, ovf, P and G clear to 0; out_valid = 0. in_ready = 1 from the first clock after rst_n deasserts.
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin. When sub = 1, cin is ignored.
- Stage 1, on an accepted beat (in_valid & in_ready):
  - registers per-bit p = a^b_eff and g = a&b_eff;
  - registers group Pk/Gk for each 4-bit group;
  - registers c0.
- Stage 2:
  - second-level lookahead: C(k+1) = Gk | Pk&Ck;
  - per-group internal carries and sum bits;
  - registers s, cout, ovf, P, G.
  - No ripple across groups is permitted; the carry path is two lookahead levels.
- Latency: exactly 2 cycles from acceptance to out_valid when out_ready stays high. Throughput is 1 beat per cycle.
- Flow control: standard valid/ready.
  - A stage advances when its downstream is empty or being drained: advance2 = !v2 | out_ready; advance1 = !v1 | advance2.
  - in_ready = advance1, combinational from out_ready and the internal valid flags only, never from in_valid.
  - The output beat holds s, cout, ovf, P and G stable while out_valid & !out_ready.
  - Capacity is 2 beats. With out_ready held low, 2 beats are accepted, then in_ready = 0.
- Simultaneous accept and drain in the same cycle: both occur, no bubble, no duplicated or dropped beat.
- Reset mid-operation: all in-flight beats are discarded. No out_valid is produced for them after reset release.
- Wrap-around: the sum is modulo 2^WIDTH and cout carries the overflowed bit. In sub mode, cout = 1 means no borrow (A >= B unsigned).
- Outputs are don't-care when out_valid = 0, except after reset, where they are 0.

Test Plan:
- WIDTH=16, add: a=0x000A, b=0x000F, cin=1 → after 2 cycles s=0x001A, cout=0, ovf=0.
- Sub: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → s=0xFFFE, cout=0, ovf=0. Swapped operands a=0x0007, b=0x0005 → s=0x0002, cout=1.
- Full-propagate chain: a=0xFFFF, b=0x0000, cin=1 → s=0x0000, cout=1, P=1, G=0, ovf=0. Signed overflow: a=0x7FFF, b=0x0001, cin=0 → s=0x8000, cout=0, ovf=1.
- Backpressure: hold out_ready=0 and drive 3 back-to-back beats (1+1, 2+2, 3+3) → in_ready=0 after 2 accepts. Release out_ready → results 2, 4, 6 in order with no loss or duplication, and outputs stable while stalled.
- Streaming: 100 random beats with random in_valid/out_ready → results match a reference model in order, full throughput whenever both handshakes are held high.
- Reset mid-operation: assert rst_n=0 with 2 beats in flight → out_valid=0 and outputs 0 immediately (asynchronous), no stale result after release. Repeat with WIDTH=4 and WIDTH=32 configurations.
